// File: rtl/multicycle_control_fsm_if.sv
// Control interface between the multicycle control FSM and the RISC-V datapath.
// Carries the opcode from the instruction register and every datapath
// mux select / write enable produced by the control unit.
//   master : control unit side (receives opcode, drives controls)
//   slave  : datapath side     (drives opcode, receives controls)
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCSource;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;

    modport master (
        input  opcode,
        output RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD,
               IRWrite, PCWrite, PCWriteCond, PCSource, ALUOp, ALUSrcB
    );

    modport slave (
        output opcode,
        input  RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD,
               IRWrite, PCWrite, PCWriteCond, PCSource, ALUOp, ALUSrcB
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle RISC-V datapath (Moore FSM, S0-S8).
// Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type and
// branch; all controls are decoded from the current state only.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (0 forces S0 immediately)
//   bus   : control interface (master side): opcode in, controls out
module multicycle_control_fsm (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_control_fsm_if.master       bus
);

    typedef enum logic [3:0] {
        S0 = 4'd0,  // fetch
        S1 = 4'd1,  // decode
        S2 = 4'd2,  // memory address
        S3 = 4'd3,  // memory read
        S4 = 4'd4,  // load writeback
        S5 = 4'd5,  // memory write
        S6 = 4'd6,  // R-type execute
        S7 = 4'd7,  // R-type completion
        S8 = 4'd8   // branch
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t state_q;
    state_t state_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; opcode only matters when leaving S1 or S2
    always_comb begin
        state_d = S0;
        case (state_q)
            S0: state_d = S1;
            S1: begin
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
                    state_d = S2;
                end else if (bus.opcode == OP_RTYPE) begin
                    state_d = S6;
                end else if (bus.opcode == OP_BRANCH || bus.opcode == OP_JALR) begin
                    state_d = S8;
                end else begin
                    state_d = S0;
                end
            end
            S2: begin
                if (bus.opcode == OP_LW) begin
                    state_d = S3;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S5;
                end else begin
                    state_d = S0;
                end
            end
            S3:      state_d = S4;
            S4:      state_d = S0;
            S5:      state_d = S0;
            S6:      state_d = S7;
            S7:      state_d = S0;
            S8:      state_d = S0;
            default: state_d = S0;  // unencoded 9-15 recover to fetch
        endcase
    end

    // Output decode; unencoded states leave every control at 0
    always_comb begin
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IorD        = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSource    = 1'b0;
        bus.ALUOp       = 2'b00;
        bus.ALUSrcB     = 2'b00;
        case (state_q)
            S0: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.PCWrite = 1'b1;
                bus.ALUSrcB = 2'b01;
            end
            S1: begin
                bus.ALUSrcB = 2'b11;
            end
            S2: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S3: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S4: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S5: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S6: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            S7: begin
                bus.RegWrite = 1'b1;
            end
            S8: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm. Control outputs are packed
// as {RegWrite,ALUSrcA,MemRead,MemWrite,MemtoReg,IorD,IRWrite,PCWrite,
//     PCWriteCond,PCSource,ALUOp[1:0],ALUSrcB[1:0]} and compared against
// hand-written per-state vectors.
module tb_multicycle_control_fsm;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    //                              RAMMMIIPPPAA BB
    localparam logic [13:0] V_S0 = 14'b00100011000001;
    localparam logic [13:0] V_S1 = 14'b00000000000011;
    localparam logic [13:0] V_S2 = 14'b01000000000010;
    localparam logic [13:0] V_S3 = 14'b00100100000000;
    localparam logic [13:0] V_S4 = 14'b10001000000000;
    localparam logic [13:0] V_S5 = 14'b00010100000000;
    localparam logic [13:0] V_S6 = 14'b01000000001000;
    localparam logic [13:0] V_S7 = 14'b10000000000000;
    localparam logic [13:0] V_S8 = 14'b01000000110100;

    function automatic logic [13:0] ctrl_vec();
        return {bus.RegWrite, bus.ALUSrcA, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.IorD, bus.IRWrite, bus.PCWrite,
                bus.PCWriteCond, bus.PCSource, bus.ALUOp, bus.ALUSrcB};
    endfunction

    task automatic check_eq(input string tag, input logic [13:0] got,
                            input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and check the resulting state's outputs
    task automatic step_check(input string tag, input logic [13:0] exp);
        @(posedge clk);
        #1;
        check_eq(tag, ctrl_vec(), exp);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        bus.opcode = OP_BAD;

        // Reset held: S0 outputs, including across a clock edge
        #2;
        check_eq("reset_async_s0", ctrl_vec(), V_S0);
        @(posedge clk);
        #1;
        check_eq("reset_held_s0", ctrl_vec(), V_S0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("reset_release_s0", ctrl_vec(), V_S0);

        // Branch via 1100111: S1, S8, S0
        bus.opcode = OP_JALR;
        step_check("br1_s1", V_S1);
        step_check("br1_s8", V_S8);
        bus.opcode = OP_LW;  // ignored when leaving S8
        step_check("br1_s0", V_S0);

        // Branch via 1100011
        bus.opcode = OP_BR;
        step_check("br2_s1", V_S1);
        step_check("br2_s8", V_S8);
        step_check("br2_s0", V_S0);

        // lw: S1, S2, S3, S4, S0; opcode changes in S3 have no effect
        bus.opcode = OP_LW;
        step_check("lw_s1", V_S1);
        step_check("lw_s2", V_S2);
        step_check("lw_s3", V_S3);
        bus.opcode = OP_R;
        step_check("lw_s4", V_S4);
        step_check("lw_s0", V_S0);

        // sw: S1, S2, S5, S0 (RegWrite stays 0 by full-vector compare)
        bus.opcode = OP_SW;
        step_check("sw_s1", V_S1);
        step_check("sw_s2", V_S2);
        step_check("sw_s5", V_S5);
        step_check("sw_s0", V_S0);

        // R-type: S1, S6, S7, S0
        bus.opcode = OP_R;
        step_check("r_s1", V_S1);
        step_check("r_s6", V_S6);
        bus.opcode = OP_SW;
        step_check("r_s7", V_S7);
        step_check("r_s0", V_S0);

        // Illegal opcode in S1 returns to fetch
        bus.opcode = OP_BAD;
        step_check("bad_s1", V_S1);
        step_check("bad_s0", V_S0);

        // Opcode changes to non-memory between S1 and S2 exits: S2 -> S0
        bus.opcode = OP_LW;
        step_check("s2x_s1", V_S1);
        step_check("s2x_s2", V_S2);
        bus.opcode = OP_R;
        step_check("s2x_s0", V_S0);

        // Mid-instruction reset pulse in S3, no clock edge involved
        bus.opcode = OP_LW;
        step_check("mid_s1", V_S1);
        step_check("mid_s2", V_S2);
        step_check("mid_s3", V_S3);
        #1;
        reset = 1'b0;
        #1;
        check_eq("mid_reset_s0", ctrl_vec(), V_S0);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_release_s0", ctrl_vec(), V_S0);
        step_check("mid_after_s1", V_S1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against any unexpected stall of the stimulus process
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
